instruction_fetch: RTL and testbench

//  Program-counter / fetch stage sitting directly upstream of the synchronous-read

---
 rtl/instruction_fetch.sv | 128 ++++++++++++
 tb/tb_instruction_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter and sits in front of a synchronous-read
// instruction memory. The PC is a word index. Because memory data arrives one
// cycle after the address, the stage remembers which PC is in flight (req_pc)
// and presents {Instr, InstrPC, InstrValid} to decode in the following cycle.
// A downstream stall freezes the stage. Any word that arrives during a stall is
// captured once into a holding register, so decode sees a stable instruction.
// A redirect reloads the PC and squashes the fetch that is in flight.
//
// Optional feature, enabled by the macro FETCH_BOUNDS_EN:
//   The stage refuses to issue a PC >= MEM_DEPTH.
//   On such an attempt it halts and raises Fault until the next Reset or Redirect.
//   Without the macro there is no range check and Fault is tied to 0.
//
// Handshake with decode:
//   InstrValid=1 and Stall=0 in the same cycle means decode takes Instr/InstrPC.
//   InstrValid=1 and Stall=1 means the word is offered but not taken.
//     The word and its PC then stay unchanged until a cycle with Stall=0.
//   InstrValid=0 is a bubble. Stall has no effect on a bubble except to
//     hold the PC.

module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic [31:0] MemAddress,
  input  logic [31:0] MemReadData,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  output logic        Fault
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;
  logic        holding_q, holding_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        issue_ok;

`ifdef FETCH_BOUNDS_EN
  logic halted_q, halted_d;

  // A PC may be issued only while not halted and inside the memory image.
  assign issue_ok = !halted_q && (pc_q < MEM_DEPTH);
`else
  assign issue_ok = 1'b1;
`endif

  // Next-state selection. Redirect beats stall, and stall beats advance.
  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    req_valid_d  = req_valid_q;
    holding_d    = holding_q;
    hold_instr_d = hold_instr_q;
`ifdef FETCH_BOUNDS_EN
    halted_d     = halted_q;
`endif
    if (Redirect) begin
      // Squash the fetch in flight. The target is issued next cycle.
      pc_d        = RedirectAddr;
      req_valid_d = 1'b0;
      holding_d   = 1'b0;
`ifdef FETCH_BOUNDS_EN
      halted_d    = 1'b0;
`endif
    end else if (Stall) begin
      // The memory re-reads the held PC next cycle.
      // Capture the offered word now, while it is still on the bus.
      if (req_valid_q && !holding_q) begin
        hold_instr_d = MemReadData;
        holding_d    = 1'b1;
      end
    end else if (issue_ok) begin
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      pc_d        = pc_q + 32'd1;
      holding_d   = 1'b0;
    end else begin
`ifdef FETCH_BOUNDS_EN
      // Out of range: freeze the PC and stop presenting instructions.
      halted_d    = 1'b1;
      req_valid_d = 1'b0;
      holding_d   = 1'b0;
`endif
    end
  end

  // State registers with synchronous reset. Reset overrides every other request.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'h0;
      req_valid_q  <= 1'b0;
      holding_q    <= 1'b0;
      hold_instr_q <= 32'h0;
`ifdef FETCH_BOUNDS_EN
      halted_q     <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      req_valid_q  <= req_valid_d;
      holding_q    <= holding_d;
      hold_instr_q <= hold_instr_d;
`ifdef FETCH_BOUNDS_EN
      halted_q     <= halted_d;
`endif
    end
  end

  assign MemAddress = pc_q;
  assign InstrPC    = req_pc_q;
  assign InstrValid = req_valid_q;
  assign Instr      = holding_q ? hold_instr_q : MemReadData;

`ifdef FETCH_BOUNDS_EN
  assign Fault = halted_q;
`else
  assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch.
// It starts with a table of directed cycles: reset, linear fetch, stall, redirect,
// redirect together with stall, and reset during a stall.
// A hand-written sequence then covers PC wrap, using a second instance with
// RESET_PC=0xFFFFFFFF.
// Another hand-written sequence covers the memory-range boundary.
// Last comes a randomized run, checked against a stream-level model.
// That model only knows which PC decode should see next and whether a bubble
// is due.
// Outputs are sampled on the falling edge. Inputs are driven right after sampling.

module tb_instruction_fetch;

  logic        clk;
  logic        rst, stall, redir;
  logic [31:0] raddr;
  logic [31:0] mem_addr, mem_rdata, instr, instr_pc;
  logic        instr_valid, fault;

  logic        rst2, stall2, redir2;
  logic [31:0] raddr2;
  logic [31:0] mem_addr2, mem_rdata2, instr2, instr_pc2;
  logic        instr_valid2, fault2;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] raddr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch #(.RESET_PC(32'h0), .MEM_DEPTH(32)) dut (
    .Clk(clk), .Reset(rst), .Stall(stall), .Redirect(redir), .RedirectAddr(raddr),
    .MemAddress(mem_addr), .MemReadData(mem_rdata), .Instr(instr),
    .InstrPC(instr_pc), .InstrValid(instr_valid), .Fault(fault)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFF), .MEM_DEPTH(32)) dut_wrap (
    .Clk(clk), .Reset(rst2), .Stall(stall2), .Redirect(redir2), .RedirectAddr(raddr2),
    .MemAddress(mem_addr2), .MemReadData(mem_rdata2), .Instr(instr2),
    .InstrPC(instr_pc2), .InstrValid(instr_valid2), .Fault(fault2)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: four preloaded words; every other address gets a distinct pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h2001_0001;
      32'd2:   return 32'hAC34_0000;
      32'd10:  return 32'h0800_0010;
      32'd16:  return 32'h2042_0002;
      default: return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Synchronous-read instruction memories, one per instance.
  always @(posedge clk) begin
    mem_rdata  <= mem_word(mem_addr);
    mem_rdata2 <= mem_word(mem_addr2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] a);
    rst = r; stall = s; redir = rd; raddr = a;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void add_vec(input logic r, input logic s, input logic rd,
                                  input logic [31:0] a, input logic v,
                                  input logic [31:0] pc, input logic [31:0] addr);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = rd; t.raddr = a;
    t.exp_valid = v; t.exp_pc = pc; t.exp_addr = addr;
    vecs.push_back(t);
  endfunction

  logic        exp_valid;
  logic [31:0] exp_pc;
  logic        r_rst, r_red, r_stall;
  logic [31:0] r_tgt;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    rst2 = 1'b1; stall2 = 1'b0; redir2 = 1'b0; raddr2 = 32'h0;

    // Directed table: in each row, the inputs for the cycle and the outputs
    // expected during that same cycle.
    add_vec(0, 0, 0, 0, 0, 0, 0);        // reset state: bubble, address 0
    add_vec(0, 0, 0, 0, 1, 0, 1);        // first word PC 0
    add_vec(0, 0, 0, 0, 1, 1, 2);
    add_vec(0, 1, 0, 0, 1, 2, 3);        // stall on PC 2 for three cycles
    add_vec(0, 1, 0, 0, 1, 2, 3);
    add_vec(0, 1, 0, 0, 1, 2, 3);
    add_vec(0, 0, 0, 0, 1, 2, 3);        // released: PC 2 consumed now
    for (int k = 3; k <= 9; k++) add_vec(0, 0, 0, 0, 1, k, k + 1);
    add_vec(0, 0, 1, 16, 1, 10, 11);     // redirect at PC 10 to 16
    add_vec(0, 0, 0, 0, 0, 0, 16);       // single bubble, word 11 never valid
    add_vec(0, 0, 0, 0, 1, 16, 17);
    add_vec(0, 1, 1, 16, 1, 17, 18);     // redirect and stall together
    add_vec(0, 0, 0, 0, 0, 0, 16);
    add_vec(0, 0, 0, 0, 1, 16, 17);
    add_vec(0, 1, 0, 0, 1, 17, 18);      // stall, then reset during the stall
    add_vec(1, 1, 0, 0, 1, 17, 18);
    add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_fault", i), {31'd0, fault}, 32'd0);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_pc", i), instr_pc, vecs[i].exp_pc);
        check($sformatf("v%0d_instr", i), instr, mem_word(vecs[i].exp_pc));
      end
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].raddr);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    // PC wrap on the instance that resets to 0xFFFFFFFF.
    rst2 = 1'b0;
    check("wrap_c0_addr", mem_addr2, 32'hFFFF_FFFF);
    check("wrap_c0_valid", {31'd0, instr_valid2}, 32'd0);
    step();
`ifndef FETCH_BOUNDS_EN
    check("wrap_c1_addr", mem_addr2, 32'h0);
    check("wrap_c1_valid", {31'd0, instr_valid2}, 32'd1);
    check("wrap_c1_pc", instr_pc2, 32'hFFFF_FFFF);
    check("wrap_c1_instr", instr2, mem_word(32'hFFFF_FFFF));
    step();
    check("wrap_c2_addr", mem_addr2, 32'h1);
    check("wrap_c2_pc", instr_pc2, 32'h0);
    check("wrap_c2_instr", instr2, 32'h2001_0001);
    check("wrap_fault", {31'd0, fault2}, 32'd0);
`else
    check("wrap_c1_valid", {31'd0, instr_valid2}, 32'd0);
    check("wrap_c1_fault", {31'd0, fault2}, 32'd1);
    check("wrap_c1_addr", mem_addr2, 32'hFFFF_FFFF);
`endif

    // Boundary of the memory image: run from 30 across 32.
    drive(1'b0, 1'b0, 1'b1, 32'd30);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("bnd_bubble", {31'd0, instr_valid}, 32'd0);
    step();
    check("bnd_pc30", instr_pc, 32'd30);
    check("bnd_v30", {31'd0, instr_valid}, 32'd1);
    step();
    check("bnd_pc31", instr_pc, 32'd31);
    check("bnd_v31", {31'd0, instr_valid}, 32'd1);
    check("bnd_f31", {31'd0, fault}, 32'd0);
    step();
`ifdef FETCH_BOUNDS_EN
    check("bnd_fault", {31'd0, fault}, 32'd1);
    check("bnd_v_after", {31'd0, instr_valid}, 32'd0);
    check("bnd_addr_frozen", mem_addr, 32'd32);
    step();
    check("bnd_still_fault", {31'd0, fault}, 32'd1);
    check("bnd_still_invalid", {31'd0, instr_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("bnd_redir_fault", {31'd0, fault}, 32'd0);
    check("bnd_redir_bubble", {31'd0, instr_valid}, 32'd0);
    step();
    check("bnd_redir_pc", instr_pc, 32'd0);
    check("bnd_redir_valid", {31'd0, instr_valid}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 32'd40);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("bnd_t40_fault0", {31'd0, fault}, 32'd0);
    step();
    check("bnd_t40_fault1", {31'd0, fault}, 32'd1);
    check("bnd_t40_invalid", {31'd0, instr_valid}, 32'd0);
`else
    check("bnd_pc32", instr_pc, 32'd32);
    check("bnd_v32", {31'd0, instr_valid}, 32'd1);
    check("bnd_f32", {31'd0, fault}, 32'd0);
`endif

    // Randomized run against the stream model.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    exp_valid = 1'b0;
    exp_pc    = 32'h0;
    for (int c = 0; c < 400; c++) begin
      check("rnd_fault", {31'd0, fault}, 32'd0);
      check("rnd_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
      if (exp_valid && instr_valid) begin
        check("rnd_pc", instr_pc, exp_pc);
        check("rnd_instr", instr, mem_word(exp_pc));
      end
      r_rst   = ($urandom_range(0, 99) < 3);
      r_red   = ($urandom_range(0, 99) < 12) || (exp_pc > 32'd24);
      r_stall = ($urandom_range(0, 99) < 30);
      r_tgt   = $urandom_range(0, 20);
      drive(r_rst, r_stall, r_red, r_tgt);
      if (r_rst) begin
        exp_valid = 1'b0;
        exp_pc    = 32'h0;
      end else if (r_red) begin
        exp_valid = 1'b0;
        exp_pc    = r_tgt;
      end else if (!r_stall) begin
        if (exp_valid) exp_pc = exp_pc + 32'd1;
        exp_valid = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
